// File: rtl/risc_pkg.sv
// Shared definitions for the multicycle RISC datapath: branch encodings,
// result-stage FSM states, flag register bit positions and default widths.
package risc_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 3;

    // Position of each ALU status flag inside the {Z,N,C,V} flag register
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_LT   = 2'b11
    } branch_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WB   = 2'b01,
        ST_BR   = 2'b10
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator. Works from the raw ALU flags of
// the instruction being captured, not from the stored flag register.
module branch_cond
    import risc_pkg::*;
(
    input  logic [1:0] branch_type,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    output logic       taken
);

    // Decode the branch type into a taken/not-taken decision
    always_comb begin
        taken = 1'b0;
        case (branch_type)
            BR_EQ:   taken = z;
            BR_NE:   taken = ~z;
            BR_LT:   taken = n ^ v;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute/writeback boundary stage: captures the ALU result and flags,
// hands the result to the register file over a valid/ready handshake and
// issues a one-cycle PC-load pulse for resolved conditional branches.
module alu_result_stage
    import risc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              flag_we,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic [1:0]        branch_type,
    input  logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        flags,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_next,
    output logic              branch_done,
    output logic              overrun
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] alu_out_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] pc_next_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic              taken_q;
    logic              pend_br_q;
    logic              overrun_q;
    logic              cond_taken;
    logic              capture;

    branch_cond u_branch_cond (
        .branch_type (branch_type),
        .z           (alu_zero),
        .n           (alu_neg),
        .v           (alu_ovf),
        .taken       (cond_taken)
    );

    assign capture = (state_q == ST_IDLE) && alu_valid;

    // State register; reset abandons any pending write or branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: writeback first, then branch, then back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (alu_valid) begin
                    if (reg_write) begin
                        state_d = ST_WB;
                    end else if (branch_type != BR_NONE) begin
                        state_d = ST_BR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = pend_br_q ? ST_BR : ST_IDLE;
                end
            end
            ST_BR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture registers load only in IDLE; a result offered while busy only raises overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            flags_q   <= '0;
            pc_next_q <= '0;
            wb_addr_q <= '0;
            taken_q   <= 1'b0;
            pend_br_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (capture) begin
                alu_out_q <= alu_result;
                wb_addr_q <= dest_reg;
                pc_next_q <= branch_target;
                taken_q   <= cond_taken;
                pend_br_q <= (branch_type != BR_NONE);
                if (flag_we) begin
                    flags_q[FLAG_Z] <= alu_zero;
                    flags_q[FLAG_N] <= alu_neg;
                    flags_q[FLAG_C] <= alu_carry;
                    flags_q[FLAG_V] <= alu_ovf;
                end
            end
            if (alu_valid && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign wb_valid    = (state_q == ST_WB);
    assign branch_done = (state_q == ST_BR);
    assign pc_load     = (state_q == ST_BR) && taken_q;
    assign alu_out     = alu_out_q;
    assign wb_data     = alu_out_q;
    assign wb_addr     = wb_addr_q;
    assign flags       = flags_q;
    assign pc_next     = pc_next_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_carry;
    logic        alu_ovf;
    logic        flag_we;
    logic        reg_write;
    logic [2:0]  dest_reg;
    logic [1:0]  branch_type;
    logic [15:0] branch_target;
    logic [15:0] alu_out;
    logic [3:0]  flags;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        branch_done;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    alu_result_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .alu_carry     (alu_carry),
        .alu_ovf       (alu_ovf),
        .flag_we       (flag_we),
        .reg_write     (reg_write),
        .dest_reg      (dest_reg),
        .branch_type   (branch_type),
        .branch_target (branch_target),
        .alu_out       (alu_out),
        .flags         (flags),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .pc_load       (pc_load),
        .pc_next       (pc_next),
        .branch_done   (branch_done),
        .overrun       (overrun)
    );

    // 10 ns free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a single cycle; flags given as {Z,N,C,V}
    task automatic applyStimulus(input logic [15:0] result, input logic [3:0] zncv,
                                 input logic fwe, input logic rw, input logic [2:0] dest,
                                 input logic [1:0] btype, input logic [15:0] target);
        alu_result    = result;
        alu_zero      = zncv[3];
        alu_neg       = zncv[2];
        alu_carry     = zncv[1];
        alu_ovf       = zncv[0];
        flag_we       = fwe;
        reg_write     = rw;
        dest_reg      = dest;
        branch_type   = btype;
        branch_target = target;
        alu_valid     = 1'b1;
        step();
        alu_valid     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0;
        alu_result = '0;
        alu_zero = 1'b0;
        alu_neg = 1'b0;
        alu_carry = 1'b0;
        alu_ovf = 1'b0;
        flag_we = 1'b0;
        reg_write = 1'b0;
        dest_reg = '0;
        branch_type = '0;
        branch_target = '0;
        wb_ready = 1'b0;

        repeat (3) step();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_alu_out", alu_out, 0);
        checkOutput("rst_flags", flags, 0);
        checkOutput("rst_pc_load", pc_load, 0);
        checkOutput("rst_branch_done", branch_done, 0);
        checkOutput("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step();

        // Plain writeback, register file ready immediately
        wb_ready = 1'b1;
        applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b1, 3'd5, 2'b00, 16'h0000);
        checkOutput("wb1_valid", wb_valid, 1);
        checkOutput("wb1_addr", wb_addr, 5);
        checkOutput("wb1_data", wb_data, 16'h1234);
        checkOutput("wb1_alu_out", alu_out, 16'h1234);
        checkOutput("wb1_in_ready", in_ready, 0);
        step();
        checkOutput("wb1_idle_ready", in_ready, 1);
        checkOutput("wb1_idle_valid", wb_valid, 0);
        wb_ready = 1'b0;

        // BEQ taken, flags written to 1000
        applyStimulus(16'h0000, 4'b1000, 1'b1, 1'b0, 3'd0, 2'b01, 16'h0040);
        checkOutput("beq_t_pc_load", pc_load, 1);
        checkOutput("beq_t_pc_next", pc_next, 16'h0040);
        checkOutput("beq_t_done", branch_done, 1);
        checkOutput("beq_t_flags", flags, 4'b1000);
        step();
        checkOutput("beq_t_pulse_end", pc_load, 0);
        checkOutput("beq_t_done_end", branch_done, 0);
        checkOutput("beq_t_idle", in_ready, 1);

        // BEQ not taken, flags not written
        applyStimulus(16'h0001, 4'b0000, 1'b0, 1'b0, 3'd0, 2'b01, 16'h0080);
        checkOutput("beq_n_pc_load", pc_load, 0);
        checkOutput("beq_n_done", branch_done, 1);
        checkOutput("beq_n_pc_next", pc_next, 16'h0080);
        checkOutput("beq_n_flags", flags, 4'b1000);
        step();

        // BLT: N=0,V=1 taken; N=1,V=1 not taken; flag register untouched
        applyStimulus(16'h8000, 4'b0001, 1'b0, 1'b0, 3'd0, 2'b11, 16'h0100);
        checkOutput("blt_t_pc_load", pc_load, 1);
        checkOutput("blt_t_flags", flags, 4'b1000);
        step();
        applyStimulus(16'h8000, 4'b0101, 1'b0, 1'b0, 3'd0, 2'b11, 16'h0200);
        checkOutput("blt_n_pc_load", pc_load, 0);
        checkOutput("blt_n_done", branch_done, 1);
        checkOutput("blt_n_flags", flags, 4'b1000);
        step();

        // Back-to-back flags-only instructions stay in IDLE
        applyStimulus(16'h4444, 4'b0110, 1'b1, 1'b0, 3'd0, 2'b00, 16'h0000);
        checkOutput("cmp1_in_ready", in_ready, 1);
        checkOutput("cmp1_flags", flags, 4'b0110);
        checkOutput("cmp1_wb_valid", wb_valid, 0);
        checkOutput("cmp1_done", branch_done, 0);
        applyStimulus(16'h5555, 4'b1010, 1'b1, 1'b0, 3'd0, 2'b00, 16'h0000);
        checkOutput("cmp2_flags", flags, 4'b1010);
        checkOutput("cmp2_alu_out", alu_out, 16'h5555);
        checkOutput("cmp2_overrun", overrun, 0);

        // Write plus BNE taken with a stalled register file
        applyStimulus(16'hBEEF, 4'b0000, 1'b0, 1'b1, 3'd3, 2'b10, 16'h0123);
        for (int i = 0; i < 2; i++) begin
            checkOutput("stall_valid", wb_valid, 1);
            checkOutput("stall_data", wb_data, 16'hBEEF);
            checkOutput("stall_addr", wb_addr, 3);
            checkOutput("stall_no_load", pc_load, 0);
            step();
        end
        // Result offered during the stall must be ignored
        applyStimulus(16'h5A5A, 4'b0100, 1'b1, 1'b1, 3'd7, 2'b01, 16'h0999);
        checkOutput("ovr_alu_out", alu_out, 16'hBEEF);
        checkOutput("ovr_addr", wb_addr, 3);
        checkOutput("ovr_pc_next", pc_next, 16'h0123);
        checkOutput("ovr_flags", flags, 4'b1010);
        checkOutput("ovr_set", overrun, 1);
        checkOutput("ovr_still_valid", wb_valid, 1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checkOutput("bne_pc_load", pc_load, 1);
        checkOutput("bne_done", branch_done, 1);
        checkOutput("bne_wb_dropped", wb_valid, 0);
        checkOutput("bne_pc_next", pc_next, 16'h0123);
        step();
        checkOutput("bne_idle", in_ready, 1);
        checkOutput("ovr_sticky", overrun, 1);

        // Asynchronous reset in the middle of a pending write plus branch
        applyStimulus(16'h7777, 4'b1000, 1'b1, 1'b1, 3'd2, 2'b01, 16'h0456);
        checkOutput("rwb_valid", wb_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rwb_valid_cleared", wb_valid, 0);
        checkOutput("rwb_alu_out", alu_out, 0);
        checkOutput("rwb_flags", flags, 0);
        checkOutput("rwb_in_ready", in_ready, 1);
        checkOutput("rwb_overrun", overrun, 0);
        checkOutput("rwb_pc_next", pc_next, 0);
        #1;
        rst_n = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rwb_no_load", pc_load, 0);
            checkOutput("rwb_no_done", branch_done, 0);
            checkOutput("rwb_no_wb", wb_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
